fetch_queue: RTL and testbench

- Parametrised next-generation instruction fetch front end.
- Owns the PC and drives a stallmem-style instruction memory port (address out, ready/data in).
- Buffers fetched instructions with their PCs in a DEPTH-entry FIFO and presents one registered instruction per cycle to decode.
- Adds redirect flush, misaligned-target error halt, and occupancy reporting on top of the single-latch fetch path.

---
 rtl/fetch_queue.sv | 191 +++++++++++++++++++
 tb/tb_fetch_queue.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front end with a prefetch FIFO.
//
// Owns the PC and drives a stallmem-style instruction memory port. Each fetched
// word is buffered together with its PC in a DEPTH-entry FIFO. The FIFO head
// moves into registered decode outputs once per unstalled cycle. A redirect
// flushes everything and reloads the PC. A misaligned redirect target also sets
// a sticky error and parks the fetcher in HALT until the next reset.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   imem_addr      fetch address (the PC register)
//   imem_req       fetch request (RUN, FIFO not full, no redirect)
//   imem_ready     imem_data is valid for imem_addr this cycle
//   imem_data      instruction word from memory
//   redirect       taken jump/branch from execute
//   redirect_addr  jump target
//   stall          downstream stall, holds the decode output registers
//   instr          instruction to decode (NOP when not valid)
//   instr_pc       PC of instr
//   instr_pc_step  instr_pc + 4
//   instr_valid    instr is a real fetched instruction
//   fq_count       FIFO occupancy
//   fetch_err      sticky misaligned-redirect error
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
  parameter logic [XLEN-1:0] NOP      = XLEN'(32'h0000_0013)
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [XLEN-1:0]          imem_addr,
  output logic                     imem_req,
  input  logic                     imem_ready,
  input  logic [XLEN-1:0]          imem_data,
  input  logic                     redirect,
  input  logic [XLEN-1:0]          redirect_addr,
  input  logic                     stall,
  output logic [XLEN-1:0]          instr,
  output logic [XLEN-1:0]          instr_pc,
  output logic [XLEN-1:0]          instr_pc_step,
  output logic                     instr_valid,
  output logic [$clog2(DEPTH):0]   fq_count,
  output logic                     fetch_err
);

  localparam int              AW      = $clog2(DEPTH);
  localparam int              CW      = AW + 1;
  localparam logic [XLEN-1:0] PC_INC  = XLEN'(4);
  localparam logic [XLEN-1:0] ZERO_W  = {XLEN{1'b0}};

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e            state_r;
  logic [XLEN-1:0]   pc_r;
  logic              fetch_err_r;

  logic [XLEN-1:0]   fifo_instr_r [DEPTH];
  logic [XLEN-1:0]   fifo_pc_r    [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;

  logic [XLEN-1:0]   instr_r;
  logic [XLEN-1:0]   instr_pc_r;
  logic [XLEN-1:0]   instr_pc_step_r;
  logic              instr_valid_r;

  logic              run_s;
  logic              full_s;
  logic              empty_s;
  logic              redirect_s;
  logic              misalign_s;
  logic              req_s;
  logic              push_s;
  logic              pop_s;

  // Control decode. Redirects only count in RUN; in HALT they are ignored.
  // The request uses the registered full flag, so a same-cycle pop never
  // opens a slot for a push until the following cycle.
  always_comb begin
    run_s      = (state_r == ST_RUN);
    full_s     = (count_r == CW'(DEPTH));
    empty_s    = (count_r == {CW{1'b0}});
    redirect_s = run_s && redirect;
    misalign_s = redirect_s && (redirect_addr[1:0] != 2'b00);
    req_s      = run_s && !full_s && !redirect;
    push_s     = req_s && imem_ready;
    pop_s      = !redirect_s && !stall && !empty_s;
  end

  // PC, run/halt state and sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_r        <= RESET_PC;
      state_r     <= ST_RUN;
      fetch_err_r <= 1'b0;
    end else if (redirect_s) begin
      pc_r <= redirect_addr;
      if (misalign_s) begin
        state_r     <= ST_HALT;
        fetch_err_r <= 1'b1;
      end else begin
        state_r     <= state_r;
        fetch_err_r <= fetch_err_r;
      end
    end else if (push_s) begin
      pc_r <= pc_r + PC_INC;
    end else begin
      pc_r <= pc_r;
    end
  end

  // Prefetch FIFO storage, pointers and occupancy; a redirect empties it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        fifo_instr_r[i] <= ZERO_W;
        fifo_pc_r[i]    <= ZERO_W;
      end
    end else if (redirect_s) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        fifo_instr_r[wr_ptr_r] <= imem_data;
        fifo_pc_r[wr_ptr_r]    <= pc_r;
        wr_ptr_r               <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Decode output registers: flush on redirect, pop when not stalled,
  // bubble (NOP) when nothing is buffered, hold under stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_r         <= NOP;
      instr_pc_r      <= ZERO_W;
      instr_pc_step_r <= ZERO_W;
      instr_valid_r   <= 1'b0;
    end else if (redirect_s) begin
      instr_r         <= NOP;
      instr_pc_r      <= ZERO_W;
      instr_pc_step_r <= ZERO_W;
      instr_valid_r   <= 1'b0;
    end else if (!stall) begin
      if (!empty_s) begin
        instr_r         <= fifo_instr_r[rd_ptr_r];
        instr_pc_r      <= fifo_pc_r[rd_ptr_r];
        instr_pc_step_r <= fifo_pc_r[rd_ptr_r] + PC_INC;
        instr_valid_r   <= 1'b1;
      end else begin
        instr_r         <= NOP;
        instr_pc_r      <= ZERO_W;
        instr_pc_step_r <= ZERO_W;
        instr_valid_r   <= 1'b0;
      end
    end else begin
      instr_r         <= instr_r;
      instr_pc_r      <= instr_pc_r;
      instr_pc_step_r <= instr_pc_step_r;
      instr_valid_r   <= instr_valid_r;
    end
  end

  assign imem_addr     = pc_r;
  assign imem_req      = req_s;
  assign instr         = instr_r;
  assign instr_pc      = instr_pc_r;
  assign instr_pc_step = instr_pc_step_r;
  assign instr_valid   = instr_valid_r;
  assign fq_count      = count_r;
  assign fetch_err     = fetch_err_r;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue. Memory returns 32'h100 + addr.
// A second instance with RESET_PC = 32'hFFFF_FFF8 covers PC wrap-around.
module tb_fetch_queue;

  localparam logic [31:0] NOP_W = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_ready;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        stall;

  logic [31:0] imem_addr, imem_data, instr, instr_pc, instr_pc_step;
  logic        imem_req, instr_valid, fetch_err;
  logic [2:0]  fq_count;

  logic [31:0] imem_addr_w, imem_data_w, instr_w, instr_pc_w, instr_pc_step_w;
  logic        imem_req_w, instr_valid_w, fetch_err_w;
  logic [2:0]  fq_count_w;

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clk = ~clk;

  assign imem_data   = 32'h0000_0100 + imem_addr;
  assign imem_data_w = 32'h0000_0100 + imem_addr_w;

  fetch_queue dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_ready(imem_ready), .imem_data(imem_data),
    .redirect(redirect), .redirect_addr(redirect_addr),
    .stall(stall),
    .instr(instr), .instr_pc(instr_pc), .instr_pc_step(instr_pc_step),
    .instr_valid(instr_valid), .fq_count(fq_count), .fetch_err(fetch_err)
  );

  fetch_queue #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr_w), .imem_req(imem_req_w),
    .imem_ready(1'b1), .imem_data(imem_data_w),
    .redirect(1'b0), .redirect_addr(32'h0000_0000),
    .stall(1'b0),
    .instr(instr_w), .instr_pc(instr_pc_w), .instr_pc_step(instr_pc_step_w),
    .instr_valid(instr_valid_w), .fq_count(fq_count_w), .fetch_err(fetch_err_w)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] exp_pc;
    rst = 1'b0; imem_ready = 1'b1; stall = 1'b0;
    redirect = 1'b0; redirect_addr = 32'h0;
    repeat (2) nxt();

    // reset state
    chk("rst_instr", instr, NOP_W);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_pc", instr_pc, 32'd0);
    chk("rst_step", instr_pc_step, 32'd0);
    chk("rst_count", 32'(fq_count), 32'd0);
    chk("rst_err", 32'(fetch_err), 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_addr_w", imem_addr_w, 32'hFFFF_FFF8);

    // streaming after release: first valid two edges later
    rst = 1'b1;
    nxt();
    chk("lat_valid0", 32'(instr_valid), 32'd0);
    chk("lat_count", 32'(fq_count), 32'd1);
    chk("lat_addr", imem_addr, 32'd4);
    nxt();
    for (int k = 0; k < 4; k++) begin
      exp_pc = 32'(4 * k);
      chk("seq_pc", instr_pc, exp_pc);
      chk("seq_instr", instr, 32'h100 + exp_pc);
      chk("seq_step", instr_pc_step, exp_pc + 32'd4);
      chk("seq_valid", 32'(instr_valid), 32'd1);
      if (k < 3) begin
        exp_pc = 32'hFFFF_FFF8 + 32'(4 * k);
        chk("wrap_pc", instr_pc_w, exp_pc);
        chk("wrap_step", instr_pc_step_w, exp_pc + 32'd4);
        chk("wrap_instr", instr_w, 32'h100 + exp_pc);
        nxt();
      end
    end

    // memory not ready for 3 cycles
    imem_ready = 1'b0;
    nxt();
    chk("nr_pc16", instr_pc, 32'd16);
    chk("nr_addr1", imem_addr, 32'd20);
    chk("nr_count", 32'(fq_count), 32'd0);
    nxt();
    chk("nr_drain", 32'(instr_valid), 32'd0);
    chk("nr_addr2", imem_addr, 32'd20);
    nxt();
    chk("nr_addr3", imem_addr, 32'd20);
    chk("nr_req", 32'(imem_req), 32'd1);
    imem_ready = 1'b1;
    nxt();
    chk("nr_bubble", 32'(instr_valid), 32'd0);
    nxt();
    chk("nr_resume_pc", instr_pc, 32'd20);
    chk("nr_resume_instr", instr, 32'h114);
    nxt();
    chk("nr_next_pc", instr_pc, 32'd24);

    // stall for 8 cycles fills the FIFO
    stall = 1'b1;
    repeat (8) nxt();
    chk("st_count", 32'(fq_count), 32'd4);
    chk("st_req", 32'(imem_req), 32'd0);
    chk("st_hold_pc", instr_pc, 32'd24);
    chk("st_hold_valid", 32'(instr_valid), 32'd1);
    chk("st_addr", imem_addr, 32'd44);
    stall = 1'b0;
    for (int k = 0; k < 5; k++) begin
      nxt();
      chk("st_drain_pc", instr_pc, 32'(28 + 4 * k));
    end
    chk("st_count3", 32'(fq_count), 32'd3);

    // redirect with 3 buffered entries while stalled
    stall = 1'b1; redirect = 1'b1; redirect_addr = 32'h200;
    #1;
    chk("rd_req_low", 32'(imem_req), 32'd0);
    nxt();
    redirect = 1'b0;
    chk("rd_count", 32'(fq_count), 32'd0);
    chk("rd_instr", instr, NOP_W);
    chk("rd_valid", 32'(instr_valid), 32'd0);
    chk("rd_addr", imem_addr, 32'h200);
    stall = 1'b0;
    nxt();
    chk("rd_bubble", 32'(instr_valid), 32'd0);
    nxt();
    chk("rd_pc", instr_pc, 32'h200);
    chk("rd_step", instr_pc_step, 32'h204);
    chk("rd_instr2", instr, 32'h300);
    chk("rd_valid2", 32'(instr_valid), 32'd1);

    // misaligned redirect halts
    redirect = 1'b1; redirect_addr = 32'h202;
    nxt();
    redirect = 1'b0;
    chk("ma_err", 32'(fetch_err), 32'd1);
    chk("ma_req", 32'(imem_req), 32'd0);
    chk("ma_instr", instr, NOP_W);
    chk("ma_valid", 32'(instr_valid), 32'd0);
    chk("ma_addr", imem_addr, 32'h202);
    redirect = 1'b1; redirect_addr = 32'h300;
    nxt();
    redirect = 1'b0;
    chk("halt_addr", imem_addr, 32'h202);
    chk("halt_err", 32'(fetch_err), 32'd1);
    chk("halt_req", 32'(imem_req), 32'd0);
    chk("halt_valid", 32'(instr_valid), 32'd0);
    nxt();
    chk("halt_count", 32'(fq_count), 32'd0);

    // asynchronous reset clears the halt
    rst = 1'b0;
    #1;
    chk("ar_err", 32'(fetch_err), 32'd0);
    chk("ar_addr", imem_addr, 32'd0);
    chk("ar_req", 32'(imem_req), 32'd1);
    nxt();
    rst = 1'b1;
    nxt();
    chk("ar_count", 32'(fq_count), 32'd1);
    nxt();
    chk("ar_pc", instr_pc, 32'd0);
    chk("ar_valid", 32'(instr_valid), 32'd1);
    chk("ar_instr", instr, 32'h100);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
